// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared constants and state encoding for the rr_arb4 arbiter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int N_REQ        = 4;
  localparam int MAX_HOLD_DEF = 15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// rr_pick4 : combinational rotated-priority search, starting after 'last'
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             found,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Walk from the lowest priority up so the highest-priority hit overwrites.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb4.sv
// ============================================================================
// rr_arb4  : 4-way round-robin arbiter with grant hold; optional hold timeout
//            compiled in with macro RR_ARB4_TIMEOUT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4: MAX_HOLD out of range 2..255");
  end

  state_t           state, state_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic [1:0]       gnt_idx_nx;
  logic [1:0]       last, last_nx;
  logic             hold;
  logic             revoke;
  logic [N_REQ-1:0] pick_req;
  logic             pick_found;
  logic [1:0]       pick_idx;

  // A revoked owner is masked out of the arbitration at the revoking edge.
  assign hold     = (state == ST_GRANT) && req[gnt_idx] && !revoke;
  assign pick_req = revoke ? (req & ~gnt) : req;
  assign gnt_vld  = |gnt;

  rr_pick4 u_pick (
    .req   (pick_req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    gnt_idx_nx = gnt_idx;
    last_nx    = last;
    if (!hold) begin
      if (pick_found) begin
        state_nx   = ST_GRANT;
        gnt_nx     = N_REQ'(1) << pick_idx;
        gnt_idx_nx = pick_idx;
        last_nx    = pick_idx;
      end else begin
        state_nx   = ST_IDLE;
        gnt_nx     = '0;
        gnt_idx_nx = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      gnt_idx <= 2'd0;
      last    <= 2'd3;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      gnt_idx <= gnt_idx_nx;
      last    <= last_nx;
    end
  end

`ifdef RR_ARB4_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       tmo_r;

  // hold_cnt is zero in the first granted cycle, so MAX_HOLD-1 marks the last one.
  assign revoke = (state == ST_GRANT) && req[gnt_idx] &&
                  (hold_cnt == 8'(MAX_HOLD - 1));
  assign tmo    = tmo_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      tmo_r    <= 1'b0;
    end else begin
      hold_cnt <= hold ? hold_cnt + 8'd1 : 8'd0;
      tmo_r    <= revoke;
    end
  end
`else
  assign revoke = 1'b0;
  assign tmo    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb4.sv
// ============================================================================
// tb_rr_arb4 : randomized self-checking bench for rr_arb4 against a queue-free
//              owner/pointer reference model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb4;

  localparam int MAX_HOLD = 4;
`ifdef RR_ARB4_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner number (-1 idle), last owner, cycles held so far.
  int m_owner;
  int m_last;
  int m_held;
  bit m_tmo;

  always #5 clk = ~clk;

  rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] r);
    int excl;
    int win;
    m_tmo = 1'b0;
    if (m_owner >= 0 && r[m_owner] && !(TMO_EN && m_held == MAX_HOLD)) begin
      m_held++;
    end else begin
      excl = -1;
      if (m_owner >= 0 && r[m_owner]) begin
        excl  = m_owner;
        m_tmo = 1'b1;
      end
      win = -1;
      for (int k = 1; k <= 4; k++) begin
        if (win < 0 && r[(m_last + k) % 4] && ((m_last + k) % 4) != excl)
          win = (m_last + k) % 4;
      end
      if (win >= 0) begin
        m_owner = win;
        m_last  = win;
        m_held  = 1;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq({tag, ".gnt"},     32'(gnt),     32'(eg));
    check_eq({tag, ".gnt_idx"}, 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_eq({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
    check_eq({tag, ".tmo"},     32'(tmo),     32'(m_tmo));
  endtask

  // Drive req at the falling edge, advance the model, check after the rising edge.
  task automatic cycle(input logic [3:0] r, input string tag);
    @(negedge clk);
    req = r;
    m_step(r);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input string tag);
    #3;
    req = 4'b0000;
    rst = 1'b1;
    #1;
    check_eq({tag, ".rst_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, ".rst_vld"}, 32'(gnt_vld), 32'd0);
    check_eq({tag, ".rst_idx"}, 32'(gnt_idx), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    m_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) cycle(4'b0000, "idle");

    cycle(4'b1010, "first");
    check_eq("first.gnt_const", 32'(gnt), 32'h2);
    cycle(4'b1000, "handover");
    check_eq("handover.gnt_const", 32'(gnt), 32'h8);
    cycle(4'b0000, "release");

    async_reset("rr_prep");
    for (int i = 0; i < 5; i++) begin
      r = 4'b1111;
      if (m_owner >= 0) r[m_owner] = 1'b0;
      cycle(r, "rr_all");
      check_eq("rr_all.order", 32'(gnt_idx), 32'(i % 4));
    end

    async_reset("own2_prep");
    cycle(4'b0100, "own2");
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1111, "own2_hold");
      if (!TMO_EN) check_eq("own2_hold.gnt_const", 32'(gnt), 32'h4);
    end
    async_reset("mid_grant");
    cycle(4'b1111, "after_rst");
    check_eq("after_rst.gnt_const", 32'(gnt), 32'h1);

    async_reset("to_pair_prep");
    for (int i = 0; i < 8; i++) cycle(4'b0011, "to_pair");
    async_reset("to_single_prep");
    for (int i = 0; i < 8; i++) cycle(4'b0001, "to_single");

    async_reset("rand_prep");
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
      cycle(r, "rand");
      if ($urandom_range(60) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
